fir_axis_engine: RTL and testbench

FIR_AXIS_ENGINE -- requirements
Module: fir_axis_engine

---
 rtl/fir_axis_engine.sv | 213 +++++++++++++++++++++
 tb/tb_fir_axis_engine.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/fir_axis_engine.sv
// Sequential FIR engine: taps and run length are loaded over AXI-Lite, samples
// stream in on ss_*, and one tap product is accumulated per cycle before each
// filtered sample is presented on sm_*.
//
// Ports
//   wb_clk_i, wb_rst_i        clock, synchronous active-high reset
//   aw*/w*                    AXI-Lite write (address and data accepted together)
//   ar*/r*                    AXI-Lite read (one outstanding read)
//   ss_tvalid/tready/tdata    input sample stream (ss_tlast unused)
//   sm_tvalid/tready/tdata    output sample stream, sm_tlast on final sample
//
// Register map: 0x00 ap_ctrl {idle, done, start}, 0x10 data_length,
//               0x40 + 4*i tap[i]. Unmapped reads return 0.
module fir_axis_engine #(
    parameter int pADDR_WIDTH = 12,
    parameter int pDATA_WIDTH = 32,
    parameter int Tape_Num    = 11
) (
    input  logic                   wb_clk_i,
    input  logic                   wb_rst_i,
    input  logic                   awvalid,
    output logic                   awready,
    input  logic [pADDR_WIDTH-1:0] awaddr,
    input  logic                   wvalid,
    output logic                   wready,
    input  logic [pDATA_WIDTH-1:0] wdata,
    input  logic                   arvalid,
    output logic                   arready,
    input  logic [pADDR_WIDTH-1:0] araddr,
    output logic                   rvalid,
    input  logic                   rready,
    output logic [pDATA_WIDTH-1:0] rdata,
    input  logic                   ss_tvalid,
    output logic                   ss_tready,
    input  logic [pDATA_WIDTH-1:0] ss_tdata,
    input  logic                   ss_tlast,
    output logic                   sm_tvalid,
    input  logic                   sm_tready,
    output logic [pDATA_WIDTH-1:0] sm_tdata,
    output logic                   sm_tlast
);

    localparam int unsigned AW = pADDR_WIDTH;
    localparam int unsigned DW = pDATA_WIDTH;
    localparam int unsigned NT = Tape_Num;
    localparam int unsigned KW = (NT > 1) ? $clog2(NT) : 1;

    localparam logic [AW-1:0] ADDR_CTRL = AW'(0);
    localparam logic [AW-1:0] ADDR_LEN  = AW'(16);
    localparam logic [AW-1:0] TAP_BASE  = AW'(64);
    localparam logic [AW-1:0] TAP_END   = AW'(64 + 4 * NT);
    localparam logic [KW-1:0] K_LAST    = KW'(NT - 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT_IN, S_MAC, S_OUT} state_t;

    state_t          state;
    logic [DW-1:0]   taps  [NT];
    logic [DW-1:0]   x_buf [NT];
    logic [DW-1:0]   data_length;
    logic [DW-1:0]   acc;
    logic [DW-1:0]   count;
    logic [KW-1:0]   k;
    logic            ap_done;
    logic            ap_idle;
    logic            rd_ctrl;
    logic [DW-1:0]   rd_mux;
    logic [DW-1:0]   mac_prod;
    logic            wr_fire;
    logic            start_req;
    logic            rd_ctrl_done;
    logic            unused_ok;

    function automatic logic is_tap(input logic [AW-1:0] a);
        return (a >= TAP_BASE) && (a < TAP_END) && (a[1:0] == 2'b00);
    endfunction

    function automatic logic [KW-1:0] tap_idx(input logic [AW-1:0] a);
        logic [AW-1:0] off;
        off = (a - TAP_BASE) >> 2;
        return KW'(off);
    endfunction

    assign unused_ok = ss_tlast;

    // Address and data are only accepted together, in the same cycle.
    assign wr_fire = awvalid && wvalid;
    assign awready = wr_fire;
    assign wready  = wr_fire;
    assign arready = !rvalid;

    assign start_req = wr_fire && (awaddr == ADDR_CTRL) && wdata[0]
                       && (state == S_IDLE) && (data_length != '0);
    assign rd_ctrl_done = rvalid && rready && rd_ctrl;

    // Low DW bits of the product are identical for signed and unsigned operands.
    assign mac_prod = DW'($signed(taps[k]) * $signed(x_buf[k]));

    // Read data mux, sampled when the read address is accepted.
    always_comb begin
        rd_mux = '0;
        if (araddr == ADDR_CTRL) begin
            rd_mux = DW'({ap_idle, ap_done, 1'b0});
        end else if (araddr == ADDR_LEN) begin
            rd_mux = data_length;
        end else if (is_tap(araddr)) begin
            rd_mux = taps[tap_idx(araddr)];
        end
    end

    // AXI-Lite read channel.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            rvalid  <= 1'b0;
            rdata   <= '0;
            rd_ctrl <= 1'b0;
        end else if (!rvalid && arvalid) begin
            rvalid  <= 1'b1;
            rdata   <= rd_mux;
            rd_ctrl <= (araddr == ADDR_CTRL);
        end else if (rvalid && rready) begin
            rvalid  <= 1'b0;
        end
    end

    // Configuration writes, control FSM and MAC datapath.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state       <= S_IDLE;
            for (int unsigned i = 0; i < NT; i++) begin
                taps[i]  <= '0;
                x_buf[i] <= '0;
            end
            data_length <= '0;
            acc         <= '0;
            count       <= '0;
            k           <= '0;
            ap_done     <= 1'b0;
            ap_idle     <= 1'b1;
            ss_tready   <= 1'b0;
            sm_tvalid   <= 1'b0;
            sm_tdata    <= '0;
            sm_tlast    <= 1'b0;
        end else begin
            if (rd_ctrl_done) begin
                ap_done <= 1'b0;
            end
            if (wr_fire && (state == S_IDLE)) begin
                if (awaddr == ADDR_LEN) begin
                    data_length <= wdata;
                end
                if (is_tap(awaddr)) begin
                    taps[tap_idx(awaddr)] <= wdata;
                end
            end

            case (state)
                S_IDLE: begin
                    if (start_req) begin
                        for (int unsigned i = 0; i < NT; i++) begin
                            x_buf[i] <= '0;
                        end
                        count     <= '0;
                        ap_done   <= 1'b0;
                        ap_idle   <= 1'b0;
                        ss_tready <= 1'b1;
                        state     <= S_WAIT_IN;
                    end
                end
                S_WAIT_IN: begin
                    // ss_tready is high throughout this state.
                    if (ss_tvalid) begin
                        x_buf[0] <= ss_tdata;
                        for (int unsigned i = 1; i < NT; i++) begin
                            x_buf[i] <= x_buf[i-1];
                        end
                        acc       <= '0;
                        k         <= '0;
                        ss_tready <= 1'b0;
                        state     <= S_MAC;
                    end
                end
                S_MAC: begin
                    acc <= acc + mac_prod;
                    k   <= k + KW'(1);
                    if (k == K_LAST) begin
                        state <= S_OUT;
                    end
                end
                S_OUT: begin
                    // First OUT cycle loads the output register; it then holds until taken.
                    if (!sm_tvalid) begin
                        sm_tvalid <= 1'b1;
                        sm_tdata  <= acc;
                        sm_tlast  <= (count == data_length - DW'(1));
                    end else if (sm_tready) begin
                        sm_tvalid <= 1'b0;
                        count     <= count + DW'(1);
                        if (sm_tlast) begin
                            ap_done <= 1'b1;
                            ap_idle <= 1'b1;
                            state   <= S_IDLE;
                        end else begin
                            ss_tready <= 1'b1;
                            state     <= S_WAIT_IN;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fir_axis_engine.sv
// Directed bench for fir_axis_engine: register access, filtering, latency,
// back-pressure, wrap-around, busy-write protection and mid-run reset.
module tb_fir_axis_engine;

    localparam int AW = 12;
    localparam int DW = 32;
    localparam int NT = 11;

    logic          clk = 1'b0;
    logic          rst;
    logic          awvalid, awready, wvalid, wready, arvalid, arready;
    logic          rvalid, rready;
    logic [AW-1:0] awaddr, araddr;
    logic [DW-1:0] wdata, rdata;
    logic          ss_tvalid, ss_tready, ss_tlast;
    logic [DW-1:0] ss_tdata;
    logic          sm_tvalid, sm_tready, sm_tlast;
    logic [DW-1:0] sm_tdata;

    int cyc      = 0;
    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fir_axis_engine #(.pADDR_WIDTH(AW), .pDATA_WIDTH(DW), .Tape_Num(NT)) dut (
        .wb_clk_i (clk),       .wb_rst_i (rst),
        .awvalid  (awvalid),   .awready  (awready),  .awaddr (awaddr),
        .wvalid   (wvalid),    .wready   (wready),   .wdata  (wdata),
        .arvalid  (arvalid),   .arready  (arready),  .araddr (araddr),
        .rvalid   (rvalid),    .rready   (rready),   .rdata  (rdata),
        .ss_tvalid(ss_tvalid), .ss_tready(ss_tready), .ss_tdata(ss_tdata), .ss_tlast(ss_tlast),
        .sm_tvalid(sm_tvalid), .sm_tready(sm_tready), .sm_tdata(sm_tdata), .sm_tlast(sm_tlast)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic axi_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        @(negedge clk);
        awvalid = 1'b1; wvalid = 1'b1; awaddr = a; wdata = d;
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
    endtask

    task automatic axi_read(input logic [AW-1:0] a, output logic [DW-1:0] d);
        int n;
        @(negedge clk);
        arvalid = 1'b1; araddr = a;
        n = 0;
        while (!arready && n < 20) begin @(negedge clk); n++; end
        @(posedge clk); #1;
        arvalid = 1'b0;
        @(negedge clk);
        n = 0;
        while (!rvalid && n < 20) begin @(negedge clk); n++; end
        d = rvalid ? rdata : 32'hBADD_0000;
        rready = 1'b1;
        @(posedge clk); #1;
        rready = 1'b0;
    endtask

    task automatic read_check(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] exp);
        logic [DW-1:0] d;
        axi_read(a, d);
        check(tag, d, exp);
    endtask

    task automatic send(input logic [DW-1:0] d, output int t_acc);
        bit ok;
        ok = 1'b0;
        @(negedge clk);
        ss_tvalid = 1'b1; ss_tdata = d;
        for (int n = 0; n < 50; n++) begin
            if (ss_tready) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        if (ok) begin @(posedge clk); #1; end
        t_acc = cyc;
        ss_tvalid = 1'b0;
        check("ss_accept", 32'(ok), 32'd1);
    endtask

    task automatic recv(input string tag, input logic [DW-1:0] exp_d, input logic exp_last,
                        output int t_valid);
        int n;
        n = 0;
        @(negedge clk);
        while (!sm_tvalid && n < 60) begin @(negedge clk); n++; end
        t_valid = cyc;
        check({tag, "_valid"}, 32'(sm_tvalid), 32'd1);
        check({tag, "_data"}, sm_tdata, exp_d);
        check({tag, "_last"}, 32'(sm_tlast), 32'(exp_last));
        sm_tready = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int t0, tv;
        logic [DW-1:0] held;
        bit seen;

        rst = 1'b1;
        awvalid = 0; wvalid = 0; arvalid = 0; rready = 0;
        awaddr = '0; araddr = '0; wdata = '0;
        ss_tvalid = 0; ss_tdata = '0; ss_tlast = 0; sm_tready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_sm_tvalid", 32'(sm_tvalid), 32'd0);
        check("rst_sm_tdata", sm_tdata, 32'd0);
        check("rst_sm_tlast", 32'(sm_tlast), 32'd0);
        check("rst_ss_tready", 32'(ss_tready), 32'd0);
        check("rst_rvalid", 32'(rvalid), 32'd0);
        check("rst_rdata", rdata, 32'd0);
        read_check("rst_ctrl", 12'h000, 32'h4);
        read_check("rst_tap1", 12'h044, 32'h0);

        // Start with zero length is ignored; unmapped space is inert
        axi_write(12'h000, 32'h1);
        read_check("len0_ctrl", 12'h000, 32'h4);
        check("len0_ss_tready", 32'(ss_tready), 32'd0);
        axi_write(12'h020, 32'h55);
        read_check("unmapped", 12'h020, 32'h0);

        // Moving sum: all taps 1, three samples
        for (int i = 0; i < NT; i++) axi_write(AW'(12'h040 + 4 * i), 32'd1);
        axi_write(12'h010, 32'd3);
        read_check("a_len", 12'h010, 32'd3);
        read_check("a_tap10", 12'h068, 32'd1);
        axi_write(12'h000, 32'h1);
        read_check("a_ctrl_busy", 12'h000, 32'h0);
        send(32'd1, t0); recv("a0", 32'd1, 1'b0, tv);
        send(32'd2, t0); recv("a1", 32'd3, 1'b0, tv);
        send(32'd3, t0); recv("a2", 32'd6, 1'b1, tv);
        read_check("a_ctrl_done", 12'h000, 32'h6);
        read_check("a_ctrl_clr", 12'h000, 32'h4);

        // Gain of two, negative input, latency and back-pressure
        axi_write(12'h040, 32'd2);
        for (int i = 1; i < NT; i++) axi_write(AW'(12'h040 + 4 * i), 32'd0);
        axi_write(12'h010, 32'd2);
        axi_write(12'h000, 32'h1);
        send(32'd5, t0); recv("b0", 32'd10, 1'b0, tv);
        check("b_latency", 32'(tv - t0), 32'd12);
        sm_tready = 1'b0;
        send(32'hFFFF_FFFD, t0);
        for (int n = 0; n < 60 && !sm_tvalid; n++) @(negedge clk);
        held = sm_tdata;
        check("b_stall_data0", held, 32'hFFFF_FFFA);
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            check("b_stall_valid", 32'(sm_tvalid), 32'd1);
            check("b_stall_data", sm_tdata, 32'hFFFF_FFFA);
            check("b_stall_last", 32'(sm_tlast), 32'd1);
            check("b_stall_ss_tready", 32'(ss_tready), 32'd0);
        end
        recv("b1", 32'hFFFF_FFFA, 1'b1, tv);
        read_check("b_ctrl_done", 12'h000, 32'h6);
        read_check("b_ctrl_clr", 12'h000, 32'h4);

        // Product wraps to zero
        axi_write(12'h040, 32'h0001_0000);
        axi_write(12'h010, 32'd1);
        axi_write(12'h000, 32'h1);
        send(32'h0001_0000, t0); recv("c0", 32'h0, 1'b1, tv);
        read_check("c_ctrl_done", 12'h000, 32'h6);

        // Writes while busy are dropped; negative tap
        axi_write(12'h040, 32'd1);
        axi_write(12'h044, 32'd3);
        axi_write(12'h048, 32'hFFFF_FFFF);
        axi_write(12'h010, 32'd3);
        axi_write(12'h000, 32'h1);
        axi_write(12'h044, 32'd7);
        axi_write(12'h010, 32'd9);
        axi_write(12'h000, 32'h1);
        read_check("d_tap1_kept", 12'h044, 32'd3);
        read_check("d_len_kept", 12'h010, 32'd3);
        send(32'd4, t0); recv("d0", 32'd4, 1'b0, tv);
        send(32'd5, t0); recv("d1", 32'd17, 1'b0, tv);
        send(32'd6, t0); recv("d2", 32'd17, 1'b1, tv);
        read_check("d_ctrl_done", 12'h000, 32'h6);
        read_check("d_ctrl_clr", 12'h000, 32'h4);

        // Reset in the middle of MAC
        axi_write(12'h040, 32'd5);
        axi_write(12'h010, 32'd1);
        axi_write(12'h000, 32'h1);
        send(32'd7, t0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("e_sm_tvalid", 32'(sm_tvalid), 32'd0);
        check("e_ss_tready", 32'(ss_tready), 32'd0);
        check("e_sm_tdata", sm_tdata, 32'd0);
        read_check("e_ctrl", 12'h000, 32'h4);
        read_check("e_len", 12'h010, 32'h0);
        for (int i = 0; i < NT; i++) read_check("e_tap", AW'(12'h040 + 4 * i), 32'h0);
        seen = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (sm_tvalid) seen = 1'b1;
        end
        check("e_quiet", 32'(seen), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
